// File: rtl/sram_arbiter_pkg.sv
// Shared requester IDs, default widths and helpers for the two-client SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int STATS_W    = 8;
  localparam int BURST_W    = 4;

  function automatic req_id_e other_req(input req_id_e id);
    if (id == REQ_A) return REQ_B;
    return REQ_A;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin picker with a bounded burst allowance; owns the
// priority pointer and burst counter and emits a one-hot grant.
module rr_pick2
  import sram_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  localparam logic [BURST_W:0] BURST_LIM = (BURST_W + 1)'(BURST_MAX);

  req_id_e            ptr_q, ptr_d, win;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [BURST_W:0]   cnt_inc;
  logic [1:0]         req_v;
  logic               both;

  // No grant may be issued while reset is held, even with requests raised.
  assign req_v   = rst_n ? req_i : 2'b00;
  assign both    = &req_v;
  assign cnt_inc = {1'b0, cnt_q} + (BURST_W + 1)'(1);

  always_comb begin
    win   = ptr_q;
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (req_v == 2'b01) win = REQ_A;
    else if (req_v == 2'b10) win = REQ_B;
    if (req_v != 2'b00) begin
      gnt_o = (win == REQ_A) ? 2'b01 : 2'b10;
      if (both && (cnt_inc >= BURST_LIM)) begin
        ptr_d = other_req(win);
        cnt_d = '0;
      end else if (win == ptr_q) begin
        // Saturate at the limit so a long solo run cannot wrap the counter.
        cnt_d = (cnt_inc >= BURST_LIM) ? BURST_LIM[BURST_W-1:0] : cnt_inc[BURST_W-1:0];
      end else begin
        ptr_d = win;
        cnt_d = (BURST_W)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_A;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between requesters A and B.
// Define ARB_STATS_EN to add saturating per-requester grant counters.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] a_gnt_cnt,
  output logic [STATS_W-1:0] b_gnt_cnt
`endif
);

  logic [1:0] gnt;
  logic       a_rvalid_q, a_rvalid_d;
  logic       b_rvalid_q, b_rvalid_d;

  rr_pick2 #(
    .BURST_MAX(BURST_MAX)
  ) u_pick (
    .clk  (clk),
    .rst_n(rst_n),
    .req_i({b_req, a_req}),
    .gnt_o(gnt)
  );

  assign a_gnt = gnt[REQ_A];
  assign b_gnt = gnt[REQ_B];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // The SRAM read port has one cycle of latency; rvalid tracks it exactly.
  assign a_rvalid_d = a_gnt & ~a_we;
  assign b_rvalid_d = b_gnt & ~b_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? mem_rdata : '0;
  assign b_rdata  = b_rvalid_q ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  logic [STATS_W-1:0] gnt_cnt_q [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gnt_cnt_q[gi] <= '0;
      else if (gnt[gi] && !(&gnt_cnt_q[gi])) gnt_cnt_q[gi] <= gnt_cnt_q[gi] + STATS_W'(1);
    end
  end

  assign a_gnt_cnt = gnt_cnt_q[0];
  assign b_gnt_cnt = gnt_cnt_q[1];
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: two arbiters (BURST_MAX 1 and 3) share stimulus, each with its own 16x4 SRAM.
module tb_sram_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          a_gnt_1, a_rvalid_1, b_gnt_1, b_rvalid_1, mem_we_1;
  logic [DW-1:0] a_rdata_1, b_rdata_1, mem_wdata_1, mem_rdata_1;
  logic [AW-1:0] mem_addr_1;
  logic          a_gnt_3, a_rvalid_3, b_gnt_3, b_rvalid_3, mem_we_3;
  logic [DW-1:0] a_rdata_3, b_rdata_3, mem_wdata_3, mem_rdata_3;
  logic [AW-1:0] mem_addr_3;
`ifdef ARB_STATS_EN
  logic [7:0] a_gnt_cnt_1, b_gnt_cnt_1, a_gnt_cnt_3, b_gnt_cnt_3;
`endif

  logic [DW-1:0] mem1 [16];
  logic [DW-1:0] mem3 [16];

  always @(posedge clk) begin
    if (mem_we_1) mem1[mem_addr_1] <= mem_wdata_1;
    mem_rdata_1 <= mem1[mem_addr_1];
    if (mem_we_3) mem3[mem_addr_3] <= mem_wdata_3;
    mem_rdata_3 <= mem3[mem_addr_3];
  end

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_1), .a_rvalid(a_rvalid_1), .a_rdata(a_rdata_1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_1), .b_rvalid(b_rvalid_1), .b_rdata(b_rdata_1),
    .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
`ifdef ARB_STATS_EN
    , .a_gnt_cnt(a_gnt_cnt_1), .b_gnt_cnt(b_gnt_cnt_1)
`endif
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_3), .a_rvalid(a_rvalid_3), .a_rdata(a_rdata_3),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_3), .b_rvalid(b_rvalid_3), .b_rdata(b_rdata_3),
    .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3)
`ifdef ARB_STATS_EN
    , .a_gnt_cnt(a_gnt_cnt_3), .b_gnt_cnt(b_gnt_cnt_3)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Tasks start and end at posedge+1, the input-drive point of a cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h7; a_wdata = 4'h9;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h4; b_wdata = 4'h2;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_gnt_1, b_gnt_1, a_rvalid_1, b_rvalid_1, mem_we_1} !== 5'b0 ||
        mem_addr_1 !== 4'h0 || mem_wdata_1 !== 4'h0 || a_rdata_1 !== 4'h0 || b_rdata_1 !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b we=%b addr=%h wdata=%h, required all 0",
               a_gnt_1, b_gnt_1, a_rvalid_1, b_rvalid_1, mem_we_1, mem_addr_1, mem_wdata_1);
    end
    checks++;
    if ({a_gnt_3, b_gnt_3, mem_we_3} !== 3'b0 || mem_addr_3 !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs_b3: gnt=%b%b we=%b addr=%h, required all 0",
               a_gnt_3, b_gnt_3, mem_we_3, mem_addr_3);
    end
    next_cycle();
    rst_n = 1'b1;
    a_we = 1'b0; a_addr = 4'h2;
    @(negedge clk);
    $display("xfer reset_release a_gnt=%b b_gnt=%b", a_gnt_1, b_gnt_1);
    checks++;
    if (a_gnt_1 !== 1'b1 || b_gnt_1 !== 1'b0 || a_gnt_3 !== 1'b1 || b_gnt_3 !== 1'b0) begin
      errors++;
      $display("FAIL first_grant: gnt1=%b%b gnt3=%b%b, required A (a=1 b=0)",
               a_gnt_1, b_gnt_1, a_gnt_3, b_gnt_3);
    end
    checks++;
    if (mem_addr_1 !== 4'h2 || mem_we_1 !== 1'b0) begin
      errors++;
      $display("FAIL first_grant_mux: addr=%h we=%b, required addr=2 we=0", mem_addr_1, mem_we_1);
    end
    next_cycle();
    do_reset();
  endtask

  task automatic test_write_read();
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h3; a_wdata = 4'hA;
    @(negedge clk);
    $display("xfer A write addr=3 data=A gnt=%b", a_gnt_1);
    checks++;
    if (a_gnt_1 !== 1'b1 || mem_we_1 !== 1'b1 || mem_addr_1 !== 4'h3 || mem_wdata_1 !== 4'hA) begin
      errors++;
      $display("FAIL wr_drive: gnt=%b we=%b addr=%h wdata=%h, required 1 1 3 A",
               a_gnt_1, mem_we_1, mem_addr_1, mem_wdata_1);
    end
    next_cycle();
    a_we = 1'b0;
    @(negedge clk);
    $display("xfer A read addr=3 gnt=%b", a_gnt_1);
    checks++;
    if (a_gnt_1 !== 1'b1 || mem_we_1 !== 1'b0 || a_rvalid_1 !== 1'b0 || b_rvalid_1 !== 1'b0) begin
      errors++;
      $display("FAIL rd_issue: gnt=%b we=%b a_rvalid=%b b_rvalid=%b, required 1 0 0 0",
               a_gnt_1, mem_we_1, a_rvalid_1, b_rvalid_1);
    end
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    $display("xfer A rdata=%h rvalid=%b", a_rdata_1, a_rvalid_1);
    checks++;
    if (a_rvalid_1 !== 1'b1 || a_rdata_1 !== 4'hA || b_rvalid_1 !== 1'b0) begin
      errors++;
      $display("FAIL rd_return: a_rvalid=%b a_rdata=%h b_rvalid=%b, required 1 A 0",
               a_rvalid_1, a_rdata_1, b_rvalid_1);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (a_rvalid_1 !== 1'b0 || a_rdata_1 !== 4'h0 || b_rvalid_1 !== 1'b0) begin
      errors++;
      $display("FAIL rd_one_cycle: a_rvalid=%b a_rdata=%h b_rvalid=%b, required 0 0 0",
               a_rvalid_1, a_rdata_1, b_rvalid_1);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [7:0] e1, e3;
    logic       p1, p3;
    // Preload: A alone writes C to addr 5 and 3 to addr 6 in both memories.
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h5; a_wdata = 4'hC;
    next_cycle();
    a_addr = 4'h6; a_wdata = 4'h3;
    next_cycle();
    do_reset();
    e1 = 8'b1010_1010;   // bit k = 1 -> B granted in cycle k
    e3 = 8'b0011_1000;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h5;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h6;
    p1 = 1'b0; p3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      $display("xfer contention cyc=%0d bm1 gnt=%b%b bm3 gnt=%b%b", k, a_gnt_1, b_gnt_1, a_gnt_3, b_gnt_3);
      checks++;
      if (a_gnt_1 !== ~e1[k] || b_gnt_1 !== e1[k]) begin
        errors++;
        $display("FAIL contention_bm1 cyc %0d: gnt a=%b b=%b, required a=%b b=%b",
                 k, a_gnt_1, b_gnt_1, ~e1[k], e1[k]);
      end
      checks++;
      if (a_gnt_3 !== ~e3[k] || b_gnt_3 !== e3[k]) begin
        errors++;
        $display("FAIL contention_bm3 cyc %0d: gnt a=%b b=%b, required a=%b b=%b",
                 k, a_gnt_3, b_gnt_3, ~e3[k], e3[k]);
      end
      if (k > 0) begin
        checks++;
        if (a_rvalid_1 !== ~p1 || b_rvalid_1 !== p1 ||
            a_rdata_1 !== (p1 ? 4'h0 : 4'hC) || b_rdata_1 !== (p1 ? 4'h3 : 4'h0)) begin
          errors++;
          $display("FAIL contention_rsp_bm1 cyc %0d: rvalid a=%b b=%b rdata a=%h b=%h, prev grant b=%b",
                   k, a_rvalid_1, b_rvalid_1, a_rdata_1, b_rdata_1, p1);
        end
        checks++;
        if (a_rvalid_3 !== ~p3 || b_rvalid_3 !== p3 ||
            a_rdata_3 !== (p3 ? 4'h0 : 4'hC) || b_rdata_3 !== (p3 ? 4'h3 : 4'h0)) begin
          errors++;
          $display("FAIL contention_rsp_bm3 cyc %0d: rvalid a=%b b=%b rdata a=%h b=%h, prev grant b=%b",
                   k, a_rvalid_3, b_rvalid_3, a_rdata_3, b_rdata_3, p3);
        end
      end
      p1 = e1[k]; p3 = e3[k];
      next_cycle();
    end
    // Only A requesting: granted every cycle in both configurations.
    b_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("xfer solo_a cyc=%0d gnt1=%b gnt3=%b", k, a_gnt_1, a_gnt_3);
      checks++;
      if (a_gnt_1 !== 1'b1 || a_gnt_3 !== 1'b1 || b_gnt_1 !== 1'b0 || b_gnt_3 !== 1'b0) begin
        errors++;
        $display("FAIL solo_a cyc %0d: a_gnt1=%b a_gnt3=%b b_gnt1=%b b_gnt3=%b, required 1 1 0 0",
                 k, a_gnt_1, a_gnt_3, b_gnt_1, b_gnt_3);
      end
      next_cycle();
    end
    a_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_cross_hazard();
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h9; a_wdata = 4'h7;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h9;
    @(negedge clk);
    checks++;
    if (a_gnt_1 !== 1'b1 || b_gnt_1 !== 1'b0) begin
      errors++;
      $display("FAIL hazard_wr_gnt: gnt a=%b b=%b, required a=1 b=0", a_gnt_1, b_gnt_1);
    end
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b_gnt_1 !== 1'b1 || a_rvalid_1 !== 1'b0 || mem_addr_1 !== 4'h9 || mem_we_1 !== 1'b0) begin
      errors++;
      $display("FAIL hazard_rd_gnt: b_gnt=%b a_rvalid=%b addr=%h we=%b, required 1 0 9 0",
               b_gnt_1, a_rvalid_1, mem_addr_1, mem_we_1);
    end
    next_cycle();
    b_req = 1'b0;
    @(negedge clk);
    $display("xfer hazard B rdata=%h rvalid=%b", b_rdata_1, b_rvalid_1);
    checks++;
    if (b_rvalid_1 !== 1'b1 || b_rdata_1 !== 4'h7 || a_rvalid_1 !== 1'b0) begin
      errors++;
      $display("FAIL hazard_rd_data: b_rvalid=%b b_rdata=%h a_rvalid=%b, required 1 7 0",
               b_rvalid_1, b_rdata_1, a_rvalid_1);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h5;
    @(negedge clk);
    checks++;
    if (a_gnt_1 !== 1'b1) begin
      errors++;
      $display("FAIL midop_gnt: a_gnt=%b, required 1", a_gnt_1);
    end
    next_cycle();
    a_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_rvalid_1 !== 1'b0 || a_rdata_1 !== 4'h0) begin
      errors++;
      $display("FAIL midop_async_clear: a_rvalid=%b a_rdata=%h, required 0 0", a_rvalid_1, a_rdata_1);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (a_rvalid_1 !== 1'b0 || a_rvalid_3 !== 1'b0 || b_rvalid_1 !== 1'b0) begin
        errors++;
        $display("FAIL midop_no_rvalid cyc %0d: a_rvalid1=%b a_rvalid3=%b b_rvalid1=%b, required 0 0 0",
                 k, a_rvalid_1, a_rvalid_3, b_rvalid_1);
      end
      next_cycle();
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h1;
    b_we = 1'b0; b_addr = 4'h2;
    repeat (10) next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_gnt_cnt_1 !== 8'd10 || b_gnt_cnt_1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_partial: a_cnt=%0d b_cnt=%0d, required 10 0", a_gnt_cnt_1, b_gnt_cnt_1);
    end
    next_cycle();
    a_req = 1'b1;
    repeat (290) next_cycle();
    b_req = 1'b1;
    repeat (6) next_cycle();
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    $display("xfer stats a_cnt1=%0d b_cnt1=%0d a_cnt3=%0d b_cnt3=%0d",
             a_gnt_cnt_1, b_gnt_cnt_1, a_gnt_cnt_3, b_gnt_cnt_3);
    checks++;
    if (a_gnt_cnt_1 !== 8'd255 || b_gnt_cnt_1 !== 8'd3) begin
      errors++;
      $display("FAIL stats_bm1: a_cnt=%0d b_cnt=%0d, required 255 3", a_gnt_cnt_1, b_gnt_cnt_1);
    end
    checks++;
    if (a_gnt_cnt_3 !== 8'd255 || b_gnt_cnt_3 !== 8'd3) begin
      errors++;
      $display("FAIL stats_bm3: a_cnt=%0d b_cnt=%0d, required 255 3", a_gnt_cnt_3, b_gnt_cnt_3);
    end
    next_cycle();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #1;
    test_reset();
    test_write_read();
    test_contention();
    test_cross_hazard();
    test_reset_midop();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares one single-port synchronous SRAM (16 x 4, write-enable, 1-cycle registered read) between two requesters, A and B.
- Round-robin arbitration with a bounded burst allowance.
- req/gnt handshake on the request side; a registered read-response valid returned to the owning requester.
- Sits between the two client blocks and the memory instance; the memory itself is instantiated outside this block.

Parameters:
ADDR_W, 4, address width; memory depth is 2**ADDR_W.
DATA_W, 4, data width.
BURST_MAX, 1, maximum consecutive grants to one requester while the other is waiting. 1 gives pure alternation. Legal range 1..15.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
a_req  in  1  requester A has a valid command.
a_we  in  1  A command is a write (1) or a read (0).
a_addr  in  ADDR_W  A address.
a_wdata  in  DATA_W  A write data.
a_gnt  out  1  A command accepted this cycle (combinational).
a_rvalid  out  1  A read data valid (registered).
a_rdata  out  DATA_W  A read data.
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
mem_we  out  1  to memory write_en.
mem_addr  out  ADDR_W  to memory addr.
mem_wdata  out  DATA_W  to memory data_in.
mem_rdata  in  DATA_W  from memory data_out.

Behaviour:
- Reset values:
  - a_gnt = b_gnt = 0 and a_rvalid = b_rvalid = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Priority pointer = A; burst counter = 0.
- Transfer rule: a command transfers in a cycle where req && gnt are both high. A requester holds req, we, addr and wdata stable until it is granted. The arbiter never drops a raised req.
- Grant (combinational, at most one per cycle):
  - Only one requester active: grant it.
  - Both active: grant the requester named by the priority pointer.
  - Neither active: no grant, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Memory drive: mem_* are driven combinationally from the granted requester. mem_we = granted we.
- Pointer and burst update (registered, on any grant):
  - If the other requester is also requesting and burst_cnt + 1 >= BURST_MAX: pointer moves to the other requester, burst_cnt = 0.
  - Else if the granted requester equals the pointer: burst_cnt increments and the pointer is kept.
  - Else: pointer moves to the granted requester, burst_cnt = 1.
  - No grant: pointer and burst_cnt hold.
- Read latency:
  - A granted read in cycle N gives x_rvalid = 1 in cycle N+1 only. x_rdata = mem_rdata in that cycle.
  - While rvalid = 0, rdata is driven 0.
  - Writes never raise rvalid.
- Back-to-back operation:
  - One transfer per cycle, so 100% memory utilisation when both requesters are busy.
  - Pipelined reads are allowed; each rvalid is one cycle wide.
- Same-address hazards: a write at N followed by a read at N+1 (either requester) returns the new data. No forwarding is performed inside this block.
- Reset mid-operation: a pending rvalid is discarded and does not appear after reset is released.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs a_gnt_cnt[7:0] and b_gnt_cnt[7:0].
  - Each counts granted transfers and saturates at 255.
  - Both reset to 0.
- Undefined: these ports and their counters do not exist; arbitration behaviour is identical in both builds.

Decomposition:
- Shared constants file: requester IDs REQ_A = 0 and REQ_B = 1, default ADDR_W / DATA_W, and the stats counter width (8).
- One natural sub-module, rr_pick2: holds the pointer and burst counter and produces the one-hot grant. The mux and rvalid pipeline stay in sram_arbiter.
- The bench instantiates sram_arbiter together with the 16 x 4 memory.

Test Plan:
- Reset check: hold rst_n = 0 with a_req = b_req = 1 → all outputs 0. First grant after release goes to A.
- Single write then read: A writes addr 3 = 0xA at N, then reads addr 3 at N+1 → a_rvalid at N+2 with a_rdata = 0xA. b_rvalid stays 0 throughout.
- Contention, BURST_MAX = 1: both requesters hold reads for 6 cycles → grants A,B,A,B,A,B, each rvalid returned the following cycle to the correct requester.
- Contention, BURST_MAX = 3: both requesting for 8 cycles → grants A,A,A,B,B,B,A,A. With only A requesting for 5 cycles → A is granted every cycle.
- Reset mid-operation: A read granted, then rst_n pulses low before the next edge → no a_rvalid after release.
- ARB_STATS_EN build: 300 A grants → a_gnt_cnt = 255; b_gnt_cnt equals the exact count of B grants.
